// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, the latched
// bus request, and the fixed strobe pattern used for instruction fetches.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_WAIT,
    I_REQ,
    I_WAIT
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic [3:0] FETCH_STRB = 4'hF;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive D grants taken while I was waiting; raises force_o once
// the limit is reached so the arbiter hands the next slot to I.
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle_i,
  input  logic i_read_i,
  input  logic d_grant_i,
  input  logic i_grant_i,
  output logic force_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign force_o = (STARVE_LIMIT != 0) && (cnt_q == LIMIT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (i_grant_i) begin
      cnt_d = '0;
    end else if (d_grant_i) begin
      if (!i_read_i)          cnt_d = '0;
      else if (cnt_q != LIMIT) cnt_d = cnt_q + CNT_W'(1);
    end else if (idle_i && force_o && !i_read_i) begin
      // I stopped asking while forced: release D on the next cycle.
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch (I) and
// load/store (D); D has priority, bounded by a starvation counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_read_i,
  input  logic [31:0] i_addr_i,
  output logic        i_ready_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_read_i,
  input  logic        d_write_i,
  input  logic [3:0]  d_strb_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ready_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_strb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  arb_state_e state_q, state_d;
  mem_req_t   req_q, req_d;
  logic       mem_req_q, mem_req_d;
  logic       err_q, err_d;
  logic       force_i, idle, d_any, d_acc, i_acc, in_wait;

  assign idle    = (state_q == IDLE);
  assign in_wait = (state_q == D_WAIT) || (state_q == I_WAIT);
  assign d_any   = d_read_i | d_write_i;

  // d_ready_o deliberately ignores the d_* inputs so it cannot close a loop
  // through the execute-stage stall logic.
  assign d_ready_o = idle & ~force_i;
  assign i_ready_o = idle & (force_i | ~d_any);
  assign d_acc     = d_any & d_ready_o;
  assign i_acc     = i_read_i & i_ready_o;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_starve (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .idle_i   (idle),
    .i_read_i (i_read_i),
    .d_grant_i(d_acc),
    .i_grant_i(i_acc),
    .force_o  (force_i)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    mem_req_d = mem_req_q;
    err_d     = err_q | (mem_rvalid_i & ~in_wait);
    unique case (state_q)
      IDLE: begin
        if (d_acc) begin
          req_d     = '{we: d_write_i, strb: d_strb_i, addr: d_addr_i, wdata: d_wdata_i};
          mem_req_d = 1'b1;
          state_d   = D_REQ;
          if (d_read_i && d_write_i) err_d = 1'b1;
        end else if (i_acc) begin
          req_d     = '{we: 1'b0, strb: FETCH_STRB, addr: i_addr_i, wdata: '0};
          mem_req_d = 1'b1;
          state_d   = I_REQ;
        end
      end
      D_REQ, I_REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = (state_q == D_REQ) ? D_WAIT : I_WAIT;
        end
      end
      D_WAIT, I_WAIT: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= '0;
      mem_req_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
      err_q     <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = req_q.we;
  assign mem_strb_o  = req_q.strb;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign err_o       = err_q;

  // Responses pass straight through to whichever requester owns the WAIT state.
  assign d_rvalid_o = (state_q == D_WAIT) & mem_rvalid_i;
  assign i_rvalid_o = (state_q == I_WAIT) & mem_rvalid_i;
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;
  assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a bus responder model, a grant/response
// monitor fed by expectation queues, and one task per scenario.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        i_read_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic        i_ready_o, i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_read_i = 1'b0, d_write_i = 1'b0;
  logic [3:0]  d_strb_i = '0;
  logic [31:0] d_addr_i = '0, d_wdata_i = '0;
  logic        d_ready_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_strb_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_o;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_ready_o(i_ready_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_read_i(d_read_i), .d_write_i(d_write_i), .d_strb_i(d_strb_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_ready_o(d_ready_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_strb_o(mem_strb_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_d;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_req_t;

  typedef struct {
    bit          is_d;
    bit          is_wr;
    logic [31:0] data;
  } exp_rsp_t;

  exp_req_t req_q[$];
  exp_rsp_t rsp_q[$];
  int total = 0;
  int bad   = 0;

  // Bus responder controls
  int          gnt_delay = 0;
  int          wait_cnt  = 0;
  bit          no_rsp = 1'b0, stray_pulse = 1'b0, stray_now = 1'b0, rsp_pend = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [31:0] rdata_next = 32'h1234_5678;

  // Bus model: grants after gnt_delay cycles, answers one cycle after the grant.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      stray_now = 1'b0;
      if (!rst_ni) begin
        rsp_pend = 1'b0; wait_cnt = 0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      end else begin
        if (rsp_pend) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = rsp_data; rsp_pend = 1'b0;
        end else if (stray_pulse) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_0BAD;
          stray_pulse = 1'b0; stray_now = 1'b1;
        end else begin
          mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
        end
        mem_gnt_i = 1'b0;
        if (mem_req_o) begin
          if (wait_cnt < gnt_delay) begin
            wait_cnt++;
          end else begin
            mem_gnt_i  = 1'b1;
            wait_cnt   = 0;
            rsp_data   = rdata_next;
            rdata_next = $urandom;
            rsp_pend   = !no_rsp;
          end
        end
      end
    end
  end

  // Scoreboard monitor: bus fields at grant, routing and data at response.
  initial begin
    exp_req_t e;
    exp_rsp_t r;
    bit ok;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (mem_req_o && mem_gnt_i) begin
          total++;
          if (req_q.size() == 0) begin
            bad++;
            $display("FAIL grant_unexpected addr=%h", mem_addr_o);
          end else begin
            e = req_q.pop_front();
            ok = (mem_we_o === e.we) && (mem_strb_o === e.strb) && (mem_addr_o === e.addr)
                 && (!e.we || mem_wdata_o === e.wdata);
            if (!ok) begin
              bad++;
              $display("FAIL bus_fields got we=%b strb=%h addr=%h wdata=%h want we=%b strb=%h addr=%h wdata=%h",
                       mem_we_o, mem_strb_o, mem_addr_o, mem_wdata_o, e.we, e.strb, e.addr, e.wdata);
            end
            if (!no_rsp) rsp_q.push_back('{is_d: e.is_d, is_wr: e.we, data: rsp_data});
          end
        end
        if (mem_rvalid_i) begin
          total++;
          if (stray_now) begin
            if (d_rvalid_o !== 1'b0 || i_rvalid_o !== 1'b0) begin
              bad++;
              $display("FAIL stray_routed got d_rvalid=%b i_rvalid=%b want 0 0", d_rvalid_o, i_rvalid_o);
            end
          end else if (rsp_q.size() == 0) begin
            bad++;
            $display("FAIL rvalid_unexpected data=%h", mem_rdata_i);
          end else begin
            r = rsp_q.pop_front();
            if (r.is_d) ok = (d_rvalid_o === 1'b1) && (i_rvalid_o === 1'b0) && (r.is_wr || d_rdata_o === r.data);
            else        ok = (i_rvalid_o === 1'b1) && (d_rvalid_o === 1'b0) && (i_rdata_o === r.data);
            if (!ok) begin
              bad++;
              $display("FAIL response got d_rvalid=%b d_rdata=%h i_rvalid=%b i_rdata=%h want %s data=%h",
                       d_rvalid_o, d_rdata_o, i_rvalid_o, i_rdata_o, r.is_d ? "D" : "I", r.data);
            end
          end
        end
      end
    end
  end

  task automatic d_issue(input logic rd, input logic wr, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bit acc = 1'b0;
    @(posedge clk_i); #1;
    d_read_i = rd; d_write_i = wr; d_strb_i = strb; d_addr_i = addr; d_wdata_i = wdata;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk_i);
      if (d_ready_o) acc = 1'b1;
    end
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL d_accept_timeout addr=%h got no d_ready want accept", addr);
    end else begin
      req_q.push_back('{is_d: 1'b1, we: wr, strb: strb, addr: addr, wdata: wdata});
    end
    @(posedge clk_i); #1;
    d_read_i = 1'b0; d_write_i = 1'b0;
  endtask

  task automatic i_issue(input logic [31:0] addr);
    bit acc = 1'b0;
    @(posedge clk_i); #1;
    i_read_i = 1'b1; i_addr_i = addr;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk_i);
      if (i_ready_o) acc = 1'b1;
    end
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL i_accept_timeout addr=%h got no i_ready want accept", addr);
    end else begin
      req_q.push_back('{is_d: 1'b0, we: 1'b0, strb: 4'hF, addr: addr, wdata: '0});
    end
    @(posedge clk_i); #1;
    i_read_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_i);
      if (req_q.size() == 0 && rsp_q.size() == 0 && i_ready_o && !mem_req_o) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL idle_timeout got req_q=%0d rsp_q=%0d want 0 0", req_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    total++;
    if ({mem_req_o, mem_we_o, mem_strb_o, mem_addr_o, mem_wdata_o, err_o,
         d_rvalid_o, i_rvalid_o, d_rdata_o, i_rdata_o} !== '0 ||
        d_ready_o !== 1'b1 || i_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got req=%b we=%b strb=%h addr=%h err=%b d_rdy=%b i_rdy=%b want zeros with ready=1",
               mem_req_o, mem_we_o, mem_strb_o, mem_addr_o, err_o, d_ready_o, i_ready_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    rdata_next = 32'hDEADBEEF;
    d_issue(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    @(negedge clk_i);
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0) begin
      bad++;
      $display("FAIL read_req_n1 got req=%b addr=%h we=%b want 1 00000100 0", mem_req_o, mem_addr_o, mem_we_o);
    end
    @(negedge clk_i);
    total++;
    if (mem_req_o !== 1'b0 || d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEADBEEF || i_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL read_rsp_n2 got req=%b d_rvalid=%b d_rdata=%h i_rvalid=%b want 0 1 deadbeef 0",
               mem_req_o, d_rvalid_o, d_rdata_o, i_rvalid_o);
    end
    @(negedge clk_i);
    total++;
    if (mem_req_o !== 1'b0 || d_rvalid_o !== 1'b0 || d_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL read_idle_n3 got req=%b d_rvalid=%b d_ready=%b want 0 0 1", mem_req_o, d_rvalid_o, d_ready_o);
    end
    wait_idle();
  endtask

  task automatic test_priority();
    fork
      d_issue(1'b0, 1'b1, 4'b0011, 32'h200, 32'hA5A5_0F0F);
      i_issue(32'h40);
    join
    wait_idle();
  endtask

  task automatic test_starvation();
    int  cnt_m = 0;
    int  n = 0;
    bit  is_i, chk_cnt = 1'b0;
    @(posedge clk_i); #1;
    i_read_i = 1'b1; i_addr_i = 32'h80;
    d_read_i = 1'b1; d_write_i = 1'b0; d_strb_i = 4'hF; d_addr_i = 32'h300;
    for (int k = 0; k < 300 && n < 6; k++) begin
      @(negedge clk_i);
      if (chk_cnt) begin
        chk_cnt = 1'b0;
        total++;
        if (dut.u_starve.cnt_q !== 3'd0) begin
          bad++;
          $display("FAIL starve_cnt_clear got %0d want 0", dut.u_starve.cnt_q);
        end
      end
      if (i_ready_o || d_ready_o) begin
        is_i = i_ready_o;
        total++;
        if (is_i != (cnt_m == LIMIT)) begin
          bad++;
          $display("FAIL starve_order grant=%0d got %s want %s", n, is_i ? "I" : "D", (cnt_m == LIMIT) ? "I" : "D");
        end
        if (is_i) begin
          total++;
          if (d_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL starve_d_block got d_ready=%b want 0", d_ready_o);
          end
          req_q.push_back('{is_d: 1'b0, we: 1'b0, strb: 4'hF, addr: 32'h80, wdata: '0});
          cnt_m = 0;
          chk_cnt = 1'b1;
        end else begin
          req_q.push_back('{is_d: 1'b1, we: 1'b0, strb: 4'hF, addr: 32'h300, wdata: '0});
          cnt_m = (cnt_m < LIMIT) ? cnt_m + 1 : LIMIT;
        end
        n++;
      end
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL starve_grants got %0d want 6", n);
    end
    @(posedge clk_i); #1;
    i_read_i = 1'b0; d_read_i = 1'b0;
    wait_idle();
  endtask

  task automatic test_gnt_stall();
    gnt_delay = 5;
    d_issue(1'b0, 1'b1, 4'b0101, 32'h400, 32'hCAFE_F00D);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      total++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h400 || mem_wdata_o !== 32'hCAFE_F00D ||
          mem_strb_o !== 4'b0101 || d_ready_o !== 1'b0 || i_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got req=%b addr=%h wdata=%h strb=%h d_rdy=%b i_rdy=%b want 1 400 cafef00d 5 0 0",
                 k, mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, d_ready_o, i_ready_o);
      end
    end
    wait_idle();
    gnt_delay = 0;
  endtask

  task automatic test_error_and_reset();
    @(negedge clk_i);
    stray_pulse = 1'b1;
    @(negedge clk_i);
    total++;
    if (err_o !== 1'b0 || mem_rvalid_i !== 1'b1) begin
      bad++;
      $display("FAIL stray_same_cycle got err=%b rvalid_in=%b want 0 1", err_o, mem_rvalid_i);
    end
    @(negedge clk_i);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_rise got %b want 1", err_o);
    end
    repeat (3) @(negedge clk_i);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got %b want 1", err_o);
    end
    no_rsp = 1'b1;
    i_issue(32'h44);
    @(negedge clk_i);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({mem_req_o, mem_we_o, mem_strb_o, mem_addr_o, mem_wdata_o, err_o,
         i_rvalid_o, d_rvalid_o, i_rdata_o, d_rdata_o} !== '0) begin
      bad++;
      $display("FAIL async_reset got req=%b strb=%h addr=%h err=%b i_rvalid=%b want all 0",
               mem_req_o, mem_strb_o, mem_addr_o, err_o, i_rvalid_o);
    end
    repeat (2) @(negedge clk_i);
    req_q.delete();
    rsp_q.delete();
    no_rsp = 1'b0;
    rst_ni = 1'b1;
    d_issue(1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
    wait_idle();
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_after_reset got %b want 0", err_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_starvation();
    test_gnt_stall();
    test_error_and_reset();
    total++;
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got req_q=%0d rsp_q=%0d want 0 0", req_q.size(), rsp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between two requesters: the instruction-fetch requester (I) and the execute-stage load/store requester (D).
- Sits between the pipeline and the memory bus.
- Accepts one transaction at a time, latches it, and drives a req/gnt request phase followed by an rvalid response phase. It then routes the response back to the requester that owns it.
- D has fixed priority. A starvation counter forces an I grant after a configurable number of back-to-back D grants.

Parameters:
- STARVE_LIMIT, 4, number of consecutive D grants while I waits before I is forced next; 0 disables forcing.
- CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- i_read_i  in  1  fetch read request
- i_addr_i  in  32  fetch word address
- i_ready_o  out  1  fetch request accepted this cycle
- i_rvalid_o  out  1  fetch response valid
- i_rdata_o  out  32  fetch response data
- d_read_i  in  1  data read request
- d_write_i  in  1  data write request
- d_strb_i  in  4  byte strobes
- d_addr_i  in  32  data word address
- d_wdata_i  in  32  write data
- d_ready_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response valid (read data or write ack)
- d_rdata_o  out  32  data read data
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write enable
- mem_strb_o  out  4  bus strobes (4'hF for fetch)
- mem_addr_o  out  32  bus address
- mem_wdata_o  out  32  bus write data
- mem_gnt_i  in  1  bus accepted the request
- mem_rvalid_i  in  1  bus response valid
- mem_rdata_i  in  32  bus read data
- err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT. Reset state is IDLE.
- Reset values: all mem_* outputs 0, latched request registers 0, starvation counter 0, err_o 0. Reset mid-transaction abandons it immediately and drops mem_req_o; any later stray response is handled as described under "unexpected response".
- d_ready_o = (state==IDLE) & ~force_i, where force_i = (STARVE_LIMIT!=0) & (cnt==STARVE_LIMIT).
  - d_ready_o must not depend combinationally on d_read_i, d_write_i or any d_* input; this prevents a loop with the execute stall path.
- i_ready_o = (state==IDLE) & (force_i | ~(d_read_i|d_write_i)).
- Acceptance:
  - D accepts on (d_read_i|d_write_i) & d_ready_o. I accepts on i_read_i & i_ready_o.
  - On accept, latch addr, wdata, strb and we (we = d_write_i; for I, we=0 and strb=4'hF), then go to X_REQ.
  - d_read_i and d_write_i both high: treat as a write and set err_o.
- X_REQ: mem_req_o=1 with the latched fields (outputs are registered). Hold them stable until mem_gnt_i=1, then go to X_WAIT.
- X_WAIT: mem_req_o=0. On mem_rvalid_i=1:
  - drive X_rvalid_o=1 and X_rdata_o=mem_rdata_i in the same cycle (combinational pass-through);
  - go to IDLE next cycle.
  - A write receives an rvalid ack; its rdata is ignored.
- Unexpected response: mem_rvalid_i in any state other than X_WAIT is ignored and sets err_o. err_o clears only on reset.
- Rvalid outputs: i_rvalid_o and d_rvalid_o are 0 outside their own WAIT state; rdata outputs are don't-care there but are driven 0.
- Latency: accept in cycle N; mem_req_o high from N+1. With gnt at N+1 and rvalid at N+2, the response is seen at N+2 and IDLE is re-entered at N+3. A new accept is possible at N+3.
- Starvation counter:
  - On a D grant while i_read_i=1: cnt++, saturating at STARVE_LIMIT.
  - On an I grant: cnt=0.
  - On a D grant with i_read_i=0: cnt=0.
  - When force_i is set, the next IDLE cycle with i_read_i=1 grants I. If I is not requesting, D is still blocked for that cycle, and force clears only on an I grant or when i_read_i=0 (then cnt resets to 0).
- Requesters must hold request fields stable until ready; the arbiter samples them only on the accept cycle.

Decomposition:
- Shared package defs.svh gains:
  - arb_state_e: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT;
  - mem_req_t struct: we, strb, addr, wdata;
  - constant FETCH_STRB = 4'hF.
- One natural sub-module, arb_starve_ctr: counter plus force_o, parameterised by STARVE_LIMIT and CNT_W. The FSM and datapath stay in mem_arbiter.

Test Plan:
1. Single D read, addr 32'h100; gnt at N+1, rvalid at N+2 with data 32'hDEADBEEF -> mem_req_o high only at N+1; d_rvalid_o=1 and d_rdata_o=32'hDEADBEEF at N+2; i_rvalid_o stays 0.
2. I and D request in the same IDLE cycle (I 32'h40, D write 32'h200, strb 4'b0011) -> D granted first with mem_we_o=1 and mem_strb_o=4'b0011; I granted at the next IDLE with mem_strb_o=4'hF.
3. STARVE_LIMIT=4; D requests continuously and I requests continuously -> 4 D grants, then 1 I grant with d_ready_o=0 during that IDLE, then the counter reads 0 and D resumes.
4. gnt held low for 5 cycles in D_REQ -> mem_addr_o, mem_wdata_o and mem_strb_o stable all 5 cycles; d_ready_o=0 and i_ready_o=0 throughout.
5. mem_rvalid_i pulsed in IDLE -> err_o rises next cycle and stays 1; no X_rvalid_o. Assert rst_ni during I_WAIT -> all outputs 0 asynchronously and err_o cleared.
